// File: rtl/arm_word_writer.sv
// arm_word_writer: buffers 32-bit ARM instruction words in a small FIFO and
// writes each one little-endian as four byte writes to the output RAM, at
// consecutive byte addresses. It counts finished words and reports done once
// a flush has drained the buffer. It reports overflow when the last address
// of the RAM has been written.
module arm_word_writer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       data,
    output logic              ready,
    input  logic              flush,
    input  logic              oram_busy,
    output logic              oram_we,
    output logic [ADDR_W-1:0] oram_addr,
    output logic [7:0]        oram_data,
    output logic [15:0]       word_count,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_BYTE1,
        S_BYTE2,
        S_BYTE3,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wordCount_q, wordCount_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              flush_q, flush_d;
    logic              we_q, we_d;
    logic [7:0]        data_q, data_d;

    logic              notEmpty;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              fifoClear;
    logic              memWrite;
    logic              lastAddr;
    logic [31:0]       headWord;

    assign notEmpty = (count_q != '0);
    assign ready    = (count_q != FULL_COUNT) && !done_q && !overflow_q;
    assign push     = start && ready;
    assign lastAddr = (addr_q == {ADDR_W{1'b1}});
    assign headWord = mem_q[rdPtr_q];

    // Next-state logic for the serializer, FIFO pointers and registered outputs.
    // An idle serializer with an empty FIFO takes an incoming word straight into
    // the shift register, so the first strobe follows the accepting edge directly.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wordCount_d = wordCount_q;
        overflow_d  = overflow_q;
        flush_d     = flush_q | flush;
        pop         = 1'b0;
        bypass      = 1'b0;
        fifoClear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (notEmpty) begin
                    pop     = 1'b1;
                    word_d  = headWord;
                    state_d = S_BYTE0;
                end else if (push) begin
                    bypass  = 1'b1;
                    word_d  = data;
                    state_d = S_BYTE0;
                end else if (flush_q) begin
                    state_d = S_DONE;
                end
            end
            S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3: begin
                if (!oram_busy) begin
                    addr_d = addr_q + ADDR_W'(1);
                    case (state_q)
                        S_BYTE0: state_d = S_BYTE1;
                        S_BYTE1: state_d = S_BYTE2;
                        S_BYTE2: state_d = S_BYTE3;
                        default: begin
                            if (wordCount_q != 16'hFFFF) begin
                                wordCount_d = wordCount_q + 16'd1;
                            end
                            if (notEmpty) begin
                                pop     = 1'b1;
                                word_d  = headWord;
                                state_d = S_BYTE0;
                            end else if (flush_q) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                    if (lastAddr) begin
                        addr_d     = addr_q;
                        overflow_d = 1'b1;
                        fifoClear  = 1'b1;
                        pop        = 1'b0;
                        word_d     = word_q;
                        state_d    = S_DONE;
                    end
                end
            end
            default: begin
            end
        endcase

        we_d   = (state_d inside {S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3});
        done_d = (state_d == S_DONE) && !overflow_d;
        case (state_d)
            S_BYTE0: data_d = word_d[7:0];
            S_BYTE1: data_d = word_d[15:8];
            S_BYTE2: data_d = word_d[23:16];
            S_BYTE3: data_d = word_d[31:24];
            default: data_d = 8'h00;
        endcase

        memWrite = push && !bypass && !fifoClear;
        if (fifoClear) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            wrPtr_d = memWrite ? wrPtr_q + PTR_W'(1) : wrPtr_q;
            rdPtr_d = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
            count_d = count_q + CNT_W'(memWrite) - CNT_W'(pop);
        end
    end

    // State register for the whole block; reset abandons any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            word_q      <= '0;
            addr_q      <= BASE;
            wordCount_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            flush_q     <= 1'b0;
            we_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wordCount_q <= wordCount_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            flush_q     <= flush_d;
            we_q        <= we_d;
            data_q      <= data_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem_q[wrPtr_q] <= data;
        end
    end

    assign oram_we    = we_q;
    assign oram_addr  = addr_q;
    assign oram_data  = data_q;
    assign word_count = wordCount_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_arm_word_writer.sv
// Testbench for arm_word_writer: directed scenarios with literal expectations
// plus randomized sessions, all cross-checked every cycle against a queue
// based behavioural model of the writer.
module tb_arm_word_writer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int BASE   = 0;

    logic              clk;
    logic              reset;
    logic              start;
    logic [31:0]       data;
    logic              ready;
    logic              flush;
    logic              oram_busy;
    logic              oram_we;
    logic [ADDR_W-1:0] oram_addr;
    logic [7:0]        oram_data;
    logic [15:0]       word_count;
    logic              done;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    arm_word_writer #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .data(data),
        .ready(ready),
        .flush(flush),
        .oram_busy(oram_busy),
        .oram_we(oram_we),
        .oram_addr(oram_addr),
        .oram_data(oram_data),
        .word_count(word_count),
        .done(done),
        .overflow(overflow)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: words waiting, the word being written and which byte.
    logic [31:0] mPending[$];
    logic [31:0] mCur;
    int          mByte;
    bit          mFinished;
    bit          mOvf;
    bit          mFlush;
    int          mWritten;
    int          mWords;
    bit          mValid = 1'b0;
    bit          mRdy;
    bit          mPsh;
    bit          mOvfEv;
    bit          mUsed;
    int          mOld;
    logic [ADDR_W-1:0] mA;

    function automatic bit mReadyFn();
        return (mPending.size() < DEPTH) && !mFinished && !mOvf;
    endfunction

    function automatic logic [ADDR_W-1:0] mAddrFn();
        if (mOvf) return {ADDR_W{1'b1}};
        return ADDR_W'(BASE + mWritten);
    endfunction

    function automatic logic [7:0] mDataFn();
        if (mByte < 0) return 8'h00;
        return 8'(mCur >> (8 * mByte));
    endfunction

    // Advance the model on every rising edge using the inputs seen at that edge.
    always @(posedge clk) begin
        if (reset) begin
            mPending.delete();
            mCur      = '0;
            mByte     = -1;
            mFinished = 1'b0;
            mOvf      = 1'b0;
            mFlush    = 1'b0;
            mWritten  = 0;
            mWords    = 0;
            mValid    = 1'b1;
        end else if (mValid) begin
            mRdy   = mReadyFn();
            mPsh   = start && mRdy;
            mOld   = mPending.size();
            mOvfEv = 1'b0;
            mUsed  = 1'b0;
            if (!mFinished) begin
                if (mByte < 0) begin
                    if (mOld > 0) begin
                        mCur  = mPending.pop_front();
                        mByte = 0;
                    end else if (mPsh) begin
                        mCur  = data;
                        mByte = 0;
                        mUsed = 1'b1;
                    end else if (mFlush) begin
                        mFinished = 1'b1;
                    end
                end else if (!oram_busy) begin
                    mA = mAddrFn();
                    mWritten++;
                    if (mByte == 3 && mWords < 65535) mWords++;
                    if (mA == {ADDR_W{1'b1}}) begin
                        mOvfEv    = 1'b1;
                        mOvf      = 1'b1;
                        mFinished = 1'b1;
                        mByte     = -1;
                        mPending.delete();
                    end else if (mByte < 3) begin
                        mByte++;
                    end else if (mOld > 0) begin
                        mCur  = mPending.pop_front();
                        mByte = 0;
                    end else begin
                        mByte = -1;
                        if (mFlush) mFinished = 1'b1;
                    end
                end
            end
            if (mPsh && !mUsed && !mOvfEv) mPending.push_back(data);
            if (flush) mFlush = 1'b1;
        end
    end

    // Completed byte writes, in order, for the directed scenarios.
    logic [ADDR_W-1:0] logAddr[$];
    logic [7:0]        logData[$];

    always @(posedge clk) begin
        if (!reset && oram_we && !oram_busy) begin
            logAddr.push_back(oram_addr);
            logData.push_back(oram_data);
        end
    end

    function automatic logic [31:0] logAddrAt(input int k);
        if (k < 0 || k >= logAddr.size()) return 'x;
        return 32'(logAddr[k]);
    endfunction

    function automatic logic [31:0] logDataAt(input int k);
        if (k < 0 || k >= logData.size()) return 'x;
        return 32'(logData[k]);
    endfunction

    int cyc = 0;
    int weCycles = 0;
    int firstWe = -1;
    int lastWe = -1;
    bit sawReadyLow = 1'b0;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        cyc++;
        if (mValid) begin
            checkOutput("ready",      32'(ready),      32'(mReadyFn()));
            checkOutput("oram_we",    32'(oram_we),    32'(mByte >= 0));
            checkOutput("oram_addr",  32'(oram_addr),  32'(mAddrFn()));
            checkOutput("oram_data",  32'(oram_data),  32'(mDataFn()));
            checkOutput("word_count", 32'(word_count), 32'(mWords));
            checkOutput("done",       32'(done),       32'(mFinished && !mOvf));
            checkOutput("overflow",   32'(overflow),   32'(mOvf));
        end
        if (oram_we) begin
            weCycles++;
            if (firstWe < 0) firstWe = cyc;
            lastWe = cyc;
        end
        if (!ready && !done && !overflow) sawReadyLow = 1'b1;
    end

    task automatic applyStimulus(input logic s, input logic [31:0] d, input logic f, input logic b);
        @(negedge clk);
        start     = s;
        data      = d;
        flush     = f;
        oram_busy = b;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        oram_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        logAddr.delete();
        logData.delete();
        weCycles    = 0;
        firstWe     = -1;
        lastWe      = -1;
        sawReadyLow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Hold start with the next word until it is accepted, like the upstream does.
    task automatic pushStream(input int n, input logic [31:0] baseWord);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            @(negedge clk);
            start = 1'b1;
            data  = baseWord + 32'(i);
            if (ready) i++;
            guard++;
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("push stream accepted", 32'(i), 32'(n));
    endtask

    logic [7:0] t1Bytes [4] = '{8'h01, 8'h00, 8'hA0, 8'hE3};
    logic [7:0] t3Bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        data      = '0;
        flush     = 1'b0;
        oram_busy = 1'b0;

        // Reset state
        doReset();
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset we", 32'(oram_we), 32'd0);
        checkOutput("reset addr", 32'(oram_addr), 32'(BASE));
        checkOutput("reset count", 32'(word_count), 32'd0);

        // Single word, no stall
        applyStimulus(1'b1, 32'hE3A00001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("t1 we", 32'(oram_we), 32'd1);
            checkOutput("t1 addr", 32'(oram_addr), 32'(k));
            checkOutput("t1 data", 32'(oram_data), 32'(t1Bytes[k]));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1 we after", 32'(oram_we), 32'd0);
        checkOutput("t1 count", 32'(word_count), 32'd1);

        // Six words back-to-back
        doReset();
        pushStream(6, 32'hA0000000);
        idle(40);
        checkOutput("t2 writes", 32'(logAddr.size()), 32'd24);
        checkOutput("t2 last addr", logAddrAt(23), 32'd23);
        checkOutput("t2 first byte", logDataAt(0), 32'h00);
        checkOutput("t2 we cycles", 32'(weCycles), 32'd24);
        checkOutput("t2 contiguous", 32'(lastWe - firstWe), 32'd23);
        checkOutput("t2 ready dropped", 32'(sawReadyLow), 32'd1);
        checkOutput("t2 count", 32'(word_count), 32'd6);
        checkOutput("t2 ready back", 32'(ready), 32'd1);

        // Stall during BYTE1
        doReset();
        applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t3 byte0", 32'(oram_data), 32'h78);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, k < 3);
            checkOutput("t3 held addr", 32'(oram_addr), 32'd1);
            checkOutput("t3 held data", 32'(oram_data), 32'h56);
        end
        idle(6);
        checkOutput("t3 we cycles", 32'(weCycles), 32'd7);
        for (int k = 0; k < 4; k++) checkOutput("t3 order", logDataAt(k), 32'(t3Bytes[k]));

        // Flush together with the second word
        doReset();
        begin
            int g = 0;
            applyStimulus(1'b1, 32'h0A0B0C0D, 1'b0, 1'b0);
            applyStimulus(1'b1, 32'h01020304, 1'b1, 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            while (!done && g < 40) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
                g++;
            end
        end
        checkOutput("t4 done reached", 32'(done), 32'd1);
        checkOutput("t4 writes at done", 32'(logAddr.size()), 32'd8);
        checkOutput("t4 we cycles", 32'(weCycles), 32'd8);
        checkOutput("t4 last byte", logDataAt(7), 32'h01);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h55555555, 1'b0, 1'b0);
            checkOutput("t4 ready low", 32'(ready), 32'd0);
        end
        idle(3);
        checkOutput("t4 count", 32'(word_count), 32'd2);
        checkOutput("t4 no more writes", 32'(logAddr.size()), 32'd8);

        // Address space exhaustion
        doReset();
        pushStream(9, 32'hB0000000);
        begin
            int g = 0;
            while (!overflow && g < 80) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
                g++;
            end
        end
        checkOutput("t5 overflow", 32'(overflow), 32'd1);
        checkOutput("t5 done low", 32'(done), 32'd0);
        checkOutput("t5 ready low", 32'(ready), 32'd0);
        checkOutput("t5 count", 32'(word_count), 32'd8);
        checkOutput("t5 last addr", logAddrAt(31), 32'd31);
        idle(6);
        checkOutput("t5 writes", 32'(logAddr.size()), 32'd32);
        checkOutput("t5 we low", 32'(oram_we), 32'd0);

        // Reset in the middle of a word
        doReset();
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hCAFEBABE, 1'b0, 1'b0);
        idle(6);
        checkOutput("t6 byte2 addr", 32'(oram_addr), 32'd6);
        checkOutput("t6 byte2 data", 32'(oram_data), 32'hFE);
        checkOutput("t6 count before", 32'(word_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6 we", 32'(oram_we), 32'd0);
        checkOutput("t6 addr", 32'(oram_addr), 32'(BASE));
        checkOutput("t6 count", 32'(word_count), 32'd0);
        checkOutput("t6 ready", 32'(ready), 32'd1);
        idle(3);
        checkOutput("t6 stays idle", 32'(oram_we), 32'd0);
        applyStimulus(1'b1, 32'h11223344, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t6 restart addr", 32'(oram_addr), 32'd0);
        checkOutput("t6 restart data", 32'(oram_data), 32'h44);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            int flushAt;
            doReset();
            flushAt = $urandom_range(10, 70);
            for (int c = 0; c < 160; c++) begin
                @(negedge clk);
                if (done || overflow) break;
                reset     = ($urandom_range(0, 199) == 0);
                start     = (c < flushAt) && ($urandom_range(0, 99) < 60);
                data      = $urandom;
                flush     = (c == flushAt);
                oram_busy = ($urandom_range(0, 99) < 25);
            end
            for (int k = 0; k < 3; k++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
            idle(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/arm_word_writer.md
Name: arm_word_writer

Overview:
- Downstream stage of the translation accelerator. Accepts 32-bit ARM instruction words from the accelerator's `valid_write`/`arm_inst` output and buffers them in a small FIFO.
- Serialises each word little-endian into byte writes on the 8-bit output RAM port, at consecutive byte addresses.
- Counts emitted words and signals completion once a flush has drained the buffer.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words (power of two, ≥2).
- ADDR_W, 8, output RAM byte-address width.
- BASE_ADDR, 0, first byte address written after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  word valid from accelerator (valid_write).
- data  in  32  ARM instruction word (arm_inst); sampled when start && ready.
- ready  out  1  FIFO can accept a word this cycle.
- flush  in  1  end-of-translation request; sampled high for ≥1 cycle.
- oram_busy  in  1  output RAM stall; no write completes while high.
- oram_we  out  1  byte write strobe.
- oram_addr  out  ADDR_W  byte address of the current write.
- oram_data  out  8  byte being written.
- word_count  out  16  number of words fully written to RAM.
- done  out  1  all flushed words written; sticky.
- overflow  out  1  address space exhausted; sticky.

Behaviour:
- Reset (reset=1 at a clock edge):
  - FIFO emptied.
  - Serializer state goes to IDLE.
  - oram_addr=BASE_ADDR.
  - word_count=0; ready=1; oram_we=0; oram_data=0; done=0; overflow=0; flush latch cleared.
  - Reset mid-word abandons the partial word; no further strobes follow.
- ready:
  - ready = !full && !done && !overflow.
  - A push happens on an edge where start && ready.
  - start while ready=0 is ignored and dropped; the upstream must hold it.
- FIFO:
  - Occupancy 0..DEPTH; read/write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves occupancy unchanged and is legal when full, but a push when full never occurs because ready=0.
- Serializer states: IDLE, BYTE0, BYTE1, BYTE2, BYTE3, DONE.
  - IDLE: if FIFO non-empty, pop the head into shift register and go to BYTE0. Else if flush latched, go to DONE.
  - BYTEk: oram_we=1, oram_data=word[8k+7:8k], oram_addr=current address (combinational from state).
  - A write completes on an edge with oram_busy=0; the address then increments and the state advances. oram_busy=1 holds the state, address and data unchanged.
  - BYTE3 completion increments word_count, then:
    - if FIFO non-empty, pop the next word directly into BYTE0 (no bubble);
    - else if flush latched, go to DONE;
    - else go to IDLE.
  - DONE: done=1, oram_we=0. Left only by reset.
- Latency:
  - First oram_we asserts in the cycle after the accepting edge when the serializer is IDLE.
  - Sustained throughput is 1 word per 4 cycles with oram_busy=0.
- Flush:
  - The flush latch is set on any edge where flush=1.
  - Words accepted in the same cycle as flush are still written before done.
  - Flush with an empty FIFO and IDLE serializer asserts done on the following cycle.
- Overflow:
  - The address does not wrap. A write completing at address 2^ADDR_W−1 sets overflow=1, and the state goes to DONE with done held 0.
  - Remaining FIFO contents are discarded and ready=0 thereafter.
- word_count saturates at 16'hFFFF.
- Width rules: the address increment is ADDR_W wide.

Test Plan:
- Reset then push 32'hE3A00001, oram_busy=0 → writes at addr 0..3: 01,00,A0,E3 on 4 consecutive cycles; word_count=1; oram_we low afterwards.
- Push 6 words back-to-back (start held) with oram_busy=0, DEPTH=4 → ready drops after the FIFO fills and recovers as words drain; 24 contiguous byte writes at addr 0..23, no gaps; word_count=6.
- Push 32'h12345678 with oram_busy high for 3 cycles during BYTE1 → addr 1 and data 8'h56 held stable for 4 cycles; total 7 cycles of oram_we; order 78,56,34,12.
- Push 2 words, assert flush in the same cycle as the 2nd push → done asserts after the 8th byte write; word_count=2; further start ignored with ready=0.
- ADDR_W=4, push 5 words → 16 bytes written (addr 0..15); overflow=1 after addr 15; word_count=4; 5th word never written; done=0.
- Assert reset in BYTE2 → next cycle oram_we=0, oram_addr=BASE_ADDR, word_count=0, ready=1; a subsequent push writes from addr 0.
